ccip_result_writer: RTL and testbench
=====================================

# ccip_result_writer

Streams solver output samples (x, y pairs) into a host-memory result buffer as CCI-P cache-line write requests. Sits between the solver and the AFU's c1 Tx channel; the AFU's MMIO block supplies the buffer address, the sample count and a start pulse. The block tracks write responses and signals completion only when every line is acknowledged by the host.

## Interface
- MAX_OUTSTANDING, 16: maximum unacknowledged write requests (power of two, ≥2)
- ADDR_W, 42: cache-line address width (CCI-P t_ccip_clAddr)

- clk  in  1  core clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches base_addr and num_samples
- base_addr  in  ADDR_W  cache-line address of buffer
- num_samples  in  32  samples to write
- in_valid  in  1  solver sample valid
- in_ready  out  1  block accepts sample this cycle
- in_x  in  64  sample x
- in_y  in  64  sample y
- c1_almfull  in  1  CCI-P c1TxAlmFull
- wr_valid  out  1  write request valid (one cycle per line)
- wr_addr  out  ADDR_W  line address
- wr_mdata  out  16  request tag = line index[15:0]
- wr_data  out  512  line payload
- wr_rsp_valid  in  1  write response received (c1 Rx)
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE until next accepted start
- lines_written  out  32  acknowledged lines

## Operation
- States: IDLE, FILL, ISSUE, DRAIN, DONE.
- IDLE/DONE + start: latch config, clear line_idx, sample count, lines_written, line buffer; go FILL. If num_samples==0, go DONE directly.
- start in FILL/ISSUE/DRAIN: ignored.
- FILL: in_ready=1. Handshake in_valid&in_ready stores sample k (0..3) at wr_data[128k+63:128k]=x, [128k+127:128k+64]=y. After 4th sample of line or last sample overall -> ISSUE. Unused slots of final partial line are zero.
- ISSUE: in_ready=0. When !c1_almfull and outstanding<MAX_OUTSTANDING: wr_valid=1 for one cycle, wr_addr=base_addr+line_idx (mod 2^ADDR_W), wr_mdata=line_idx[15:0]; line_idx++, buffer cleared; next FILL if samples remain, else DRAIN.
- Outstanding counter: +1 on issue, −1 on wr_rsp_valid; simultaneous → unchanged. Response at outstanding==0 ignored (no underflow). Each counted response increments lines_written.
- DRAIN: outstanding==0 -> DONE.
- Lines issued = ceil(num_samples/4).

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, wr_data 0, counters 0. Responses arriving after reset for pre-reset requests are ignored per underflow rule.
- wr_valid, wr_addr, wr_mdata, wr_data, busy, done, lines_written registered.
- Sample accepted in cycle N; if it completes a line, wr_valid asserts earliest N+2 (ISSUE entered N+1, request registered).
- Steady state without back-pressure: 4 samples per 5 cycles.
- c1_almfull sampled in ISSUE; high → request held, no wr_valid.
- done rises one cycle after final response decrements outstanding to 0; busy falls same cycle.

## Structure
- Shared package ccip_writer_pkg: state enum, SAMPLES_PER_LINE=4, sample width 128, line width 512.
- One sub-module: ccip_outstanding_ctr (up/down counter with saturate-at-zero, full flag at MAX_OUTSTANDING).

## Test plan
- base_addr=0x1000, num_samples=4, x=1..4, y=0x10..0x13 -> one wr_valid, addr 0x1000, mdata 0, slot k = {y,x}; one response -> done=1, lines_written=1.
- num_samples=6 -> two writes at 0x1000, 0x1001; second line slots 2,3 zero; done after both responses.
- c1_almfull held 10 cycles in ISSUE -> no wr_valid, in_ready=0; released -> wr_valid 1 cycle later.
- MAX_OUTSTANDING=2, num_samples=16, no responses -> exactly 2 writes then stall; one response -> third write; response and issue same cycle -> outstanding unchanged.
- num_samples=0 -> done=1 next cycle, no wr_valid.
- reset_n low mid-FILL -> all outputs 0 immediately; stray response after release -> lines_written stays 0.

Source files
------------

// File: rtl/ccip_writer_pkg.sv
// Shared types and constants for the CCI-P result writer: FSM states and
// the sample/line geometry used to pack solver samples into cache lines.
package ccip_writer_pkg;

    localparam int SAMPLES_PER_LINE = 4;
    localparam int SAMPLE_W         = 128;
    localparam int LINE_W           = 512;
    localparam int SLOT_W           = $clog2(SAMPLES_PER_LINE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic is_active(input state_e s);
        return (s == ST_FILL) || (s == ST_ISSUE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/ccip_outstanding_ctr.sv
// Up/down counter of unacknowledged write requests; responses arriving while
// the count is zero are dropped so stale host acks can never underflow it.
module ccip_outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic dec_taken
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign dec_taken = dec && (count_q != '0);
    assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty     = (count_q == '0);

    always_comb begin
        count_d = count_q;
        case ({inc, dec_taken})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ccip_result_writer.sv
// Packs solver (x, y) samples four to a cache line and issues them as CCI-P
// c1 write requests, reporting completion once every line has been acked.
module ccip_result_writer
    import ccip_writer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int ADDR_W          = 42
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_x,
    input  logic [63:0]       in_y,
    input  logic              c1_almfull,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_mdata,
    output logic [LINE_W-1:0] wr_data,
    input  logic              wr_rsp_valid,
    output logic              busy,
    output logic              done,
    output logic [31:0]       lines_written
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
    logic [31:0]         num_samples_q, num_samples_d;
    logic [31:0]         samples_taken_q, samples_taken_d;
    logic [31:0]         line_idx_q, line_idx_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [LINE_W-1:0]   line_buf_q, line_buf_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_mdata_q, wr_mdata_d;
    logic [LINE_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         lines_written_q, lines_written_d;

    logic issue_fire;
    logic ctr_full;
    logic ctr_empty;
    logic rsp_taken;

    ccip_outstanding_ctr #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_outstanding (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (issue_fire),
        .dec      (wr_rsp_valid),
        .full     (ctr_full),
        .empty    (ctr_empty),
        .dec_taken(rsp_taken)
    );

    assign in_ready      = (state_q == ST_FILL);
    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_mdata      = wr_mdata_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_written = lines_written_q;

    always_comb begin
        state_d         = state_q;
        base_addr_d     = base_addr_q;
        num_samples_d   = num_samples_q;
        samples_taken_d = samples_taken_q;
        line_idx_d      = line_idx_q;
        slot_d          = slot_q;
        line_buf_d      = line_buf_q;
        wr_valid_d      = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_mdata_d      = wr_mdata_q;
        wr_data_d       = wr_data_q;
        lines_written_d = lines_written_q + 32'(rsp_taken);
        issue_fire      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    base_addr_d     = base_addr;
                    num_samples_d   = num_samples;
                    samples_taken_d = '0;
                    line_idx_d      = '0;
                    slot_d          = '0;
                    line_buf_d      = '0;
                    lines_written_d = '0;
                    state_d         = (num_samples == 32'd0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    line_buf_d[int'(slot_q)*SAMPLE_W +: SAMPLE_W] = {in_y, in_x};
                    samples_taken_d = samples_taken_q + 32'd1;
                    slot_d          = slot_q + 1'b1;
                    if ((slot_q == SLOT_W'(SAMPLES_PER_LINE - 1)) ||
                        (samples_taken_d == num_samples_q)) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // The buffer moves into the output register on issue so the
                // next line can start filling while the request is on the bus.
                if (!c1_almfull && !ctr_full) begin
                    issue_fire = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = base_addr_q + ADDR_W'(line_idx_q);
                    wr_mdata_d = line_idx_q[15:0];
                    wr_data_d  = line_buf_q;
                    line_idx_d = line_idx_q + 32'd1;
                    line_buf_d = '0;
                    slot_d     = '0;
                    state_d    = (samples_taken_q == num_samples_q) ? ST_DRAIN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (ctr_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = is_active(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            base_addr_q     <= '0;
            num_samples_q   <= '0;
            samples_taken_q <= '0;
            line_idx_q      <= '0;
            slot_q          <= '0;
            line_buf_q      <= '0;
            wr_valid_q      <= 1'b0;
            wr_addr_q       <= '0;
            wr_mdata_q      <= '0;
            wr_data_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            lines_written_q <= '0;
        end else begin
            state_q         <= state_d;
            base_addr_q     <= base_addr_d;
            num_samples_q   <= num_samples_d;
            samples_taken_q <= samples_taken_d;
            line_idx_q      <= line_idx_d;
            slot_q          <= slot_d;
            line_buf_q      <= line_buf_d;
            wr_valid_q      <= wr_valid_d;
            wr_addr_q       <= wr_addr_d;
            wr_mdata_q      <= wr_mdata_d;
            wr_data_q       <= wr_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            lines_written_q <= lines_written_d;
        end
    end

endmodule

// File: tb/tb_ccip_result_writer.sv
// Directed bench for ccip_result_writer: a table of whole-buffer transfers
// plus hand-written sequences for back-pressure, stall, zero-length and reset.
module tb_ccip_result_writer;

    localparam int ADDR_W = 42;
    localparam int MAXO   = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       num_samples;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_x;
    logic [63:0]       in_y;
    logic              c1_almfull;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_mdata;
    logic [511:0]      wr_data;
    logic              wr_rsp_valid;
    logic              busy;
    logic              done;
    logic [31:0]       lines_written;

    logic auto_rsp       = 1'b0;
    logic auto_rsp_pulse = 1'b0;
    logic man_rsp        = 1'b0;
    int   pend           = 0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       mdata;
        logic [511:0]      data;
    } wr_rec_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                n;
        int                exp_lines;
        logic [ADDR_W-1:0] exp_last_addr;
    } vec_t;

    wr_rec_t cap[$];
    vec_t    vecs[5];

    assign wr_rsp_valid = auto_rsp_pulse | man_rsp;

    always #5 clk = ~clk;

    ccip_result_writer #(
        .MAX_OUTSTANDING(MAXO),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .c1_almfull   (c1_almfull),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_mdata     (wr_mdata),
        .wr_data      (wr_data),
        .wr_rsp_valid (wr_rsp_valid),
        .busy         (busy),
        .done         (done),
        .lines_written(lines_written)
    );

    // Record every request the DUT presents during the cycle before this edge
    always @(posedge clk) begin
        if (reset_n && wr_valid) begin
            cap.push_back('{wr_addr, wr_mdata, wr_data});
        end
    end

    // Host model: acknowledge each request one cycle after it is seen
    always @(negedge clk) begin
        auto_rsp_pulse = 1'b0;
        if (auto_rsp && pend > 0) begin
            auto_rsp_pulse = 1'b1;
            pend--;
        end
        if (auto_rsp && wr_valid) begin
            pend++;
        end
    end

    function automatic logic [63:0] sample_x(input int v, input int i);
        return {32'(v), 32'(i + 1)};
    endfunction

    function automatic logic [63:0] sample_y(input int v, input int i);
        return {32'(v), 32'(16 + i)};
    endfunction

    function automatic logic [511:0] expected_line(input int v, input int n, input int j);
        logic [511:0] line;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            if (4 * j + k < n) begin
                line[128*k +: 128] = {sample_y(v, 4 * j + k), sample_x(v, 4 * j + k)};
            end
        end
        return line;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input int n);
        @(negedge clk);
        start       = 1'b1;
        base_addr   = b;
        num_samples = n;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic feed(input int v, input int first, input int count);
        int i     = 0;
        int guard = 0;
        while (i < count && guard < 2000) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = sample_x(v, first + i);
            in_y     = sample_y(v, first + i);
            if (in_ready) i++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (i < count) checkOutput("feed_timeout", 512'(i), 512'(count));
    endtask

    task automatic pulse_rsp();
        @(negedge clk);
        man_rsp = 1'b1;
        @(negedge clk);
        man_rsp = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        checkOutput(name, 512'(done), 512'(1));
    endtask

    task automatic wait_wr_valid(input string name, input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wr_valid && t < budget);
        checkOutput(name, 512'(wr_valid), 512'(1));
    endtask

    task automatic applyStimulus(input int vi);
        cap.delete();
        auto_rsp = 1'b1;
        do_start(vecs[vi].base, vecs[vi].n);
        checkOutput($sformatf("v%0d_done_clr", vi), 512'(done), 512'(0));
        checkOutput($sformatf("v%0d_busy", vi), 512'(busy), 512'(1));
        feed(vi, 0, vecs[vi].n);
        wait_done($sformatf("v%0d_done", vi), 300);
    endtask

    task automatic checkVector(input int vi);
        logic [ADDR_W-1:0] a;
        checkOutput($sformatf("v%0d_nlines", vi), 512'(cap.size()), 512'(vecs[vi].exp_lines));
        for (int j = 0; j < cap.size() && j < vecs[vi].exp_lines; j++) begin
            a = vecs[vi].base + ADDR_W'(j);
            checkOutput($sformatf("v%0d_addr%0d", vi, j), 512'(cap[j].addr), 512'(a));
            checkOutput($sformatf("v%0d_mdata%0d", vi, j), 512'(cap[j].mdata), 512'(j));
            checkOutput($sformatf("v%0d_data%0d", vi, j), cap[j].data, expected_line(vi, vecs[vi].n, j));
        end
        if (cap.size() > 0) begin
            checkOutput($sformatf("v%0d_last_addr", vi), 512'(cap[cap.size()-1].addr),
                        512'(vecs[vi].exp_last_addr));
        end
        checkOutput($sformatf("v%0d_lines_written", vi), 512'(lines_written), 512'(vecs[vi].exp_lines));
        checkOutput($sformatf("v%0d_busy_end", vi), 512'(busy), 512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vecs[0] = '{42'h1000,         4, 1, 42'h1000};
        vecs[1] = '{42'h1000,         6, 2, 42'h1001};
        vecs[2] = '{42'h2000,         1, 1, 42'h2000};
        vecs[3] = '{42'h3000,         9, 3, 42'h3002};
        vecs[4] = '{42'h3FF_FFFF_FFFF, 8, 2, 42'h0};

        reset_n     = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        num_samples = '0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_y        = '0;
        c1_almfull  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_valid", 512'(wr_valid), 512'(0));
        checkOutput("rst_in_ready", 512'(in_ready), 512'(0));
        checkOutput("rst_busy", 512'(busy), 512'(0));
        checkOutput("rst_done", 512'(done), 512'(0));
        checkOutput("rst_lines", 512'(lines_written), 512'(0));
        checkOutput("rst_wr_data", wr_data, 512'(0));
        reset_n = 1'b1;

        // Zero-length buffer completes immediately without touching the bus
        cap.delete();
        do_start(42'h5000, 0);
        checkOutput("zero_done", 512'(done), 512'(1));
        checkOutput("zero_busy", 512'(busy), 512'(0));
        repeat (3) @(negedge clk);
        checkOutput("zero_nwrites", 512'(cap.size()), 512'(0));

        for (int vi = 0; vi < 5; vi++) begin
            applyStimulus(vi);
            checkVector(vi);
        end

        // Almost-full back-pressure holds a completed line in ISSUE
        cap.delete();
        auto_rsp   = 1'b1;
        c1_almfull = 1'b1;
        do_start(42'h7000, 4);
        feed(5, 0, 4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("af_wr_valid%0d", c), 512'(wr_valid), 512'(0));
            checkOutput($sformatf("af_in_ready%0d", c), 512'(in_ready), 512'(0));
        end
        c1_almfull = 1'b0;
        @(negedge clk);
        checkOutput("af_release_valid", 512'(wr_valid), 512'(1));
        checkOutput("af_release_addr", 512'(wr_addr), 512'(42'h7000));
        checkOutput("af_release_data", wr_data, expected_line(5, 4, 0));
        @(negedge clk);
        checkOutput("af_single_cycle", 512'(wr_valid), 512'(0));
        wait_done("af_done", 50);
        checkOutput("af_nwrites", 512'(cap.size()), 512'(1));
        checkOutput("af_lines", 512'(lines_written), 512'(1));

        // Outstanding limit of two: stall, release by one ack, then ack+issue together
        cap.delete();
        auto_rsp = 1'b0;
        do_start(42'hA000, 16);
        feed(7, 0, 12);
        repeat (8) @(negedge clk);
        checkOutput("st_nwrites2", 512'(cap.size()), 512'(2));
        checkOutput("st_in_ready", 512'(in_ready), 512'(0));
        checkOutput("st_wr_valid", 512'(wr_valid), 512'(0));
        pulse_rsp();
        wait_wr_valid("st_third_issue", 10);
        checkOutput("st_third_addr", 512'(wr_addr), 512'(42'hA002));
        checkOutput("st_third_mdata", 512'(wr_mdata), 512'(2));
        @(negedge clk);
        checkOutput("st_nwrites3", 512'(cap.size()), 512'(3));
        checkOutput("st_lines1", 512'(lines_written), 512'(1));
        pulse_rsp();
        feed(7, 12, 4);
        man_rsp = 1'b1;
        @(negedge clk);
        man_rsp = 1'b0;
        checkOutput("st_simul_issue", 512'(wr_valid), 512'(1));
        checkOutput("st_simul_addr", 512'(wr_addr), 512'(42'hA003));
        checkOutput("st_lines3", 512'(lines_written), 512'(3));
        repeat (6) @(negedge clk);
        checkOutput("st_drain_done", 512'(done), 512'(0));
        checkOutput("st_drain_busy", 512'(busy), 512'(1));
        checkOutput("st_nwrites4", 512'(cap.size()), 512'(4));
        pulse_rsp();
        wait_done("st_done", 10);
        checkOutput("st_lines4", 512'(lines_written), 512'(4));

        // Reset in the middle of filling a line, then a stray ack
        cap.delete();
        do_start(42'h9000, 12);
        feed(9, 0, 4);
        repeat (2) @(negedge clk);
        pulse_rsp();
        feed(9, 4, 4);
        feed(9, 8, 2);
        checkOutput("mr_pre_lines", 512'(lines_written), 512'(1));
        checkOutput("mr_pre_addr", 512'(wr_addr), 512'(42'h9001));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("mr_wr_valid", 512'(wr_valid), 512'(0));
        checkOutput("mr_wr_addr", 512'(wr_addr), 512'(0));
        checkOutput("mr_wr_mdata", 512'(wr_mdata), 512'(0));
        checkOutput("mr_wr_data", wr_data, 512'(0));
        checkOutput("mr_busy", 512'(busy), 512'(0));
        checkOutput("mr_done", 512'(done), 512'(0));
        checkOutput("mr_lines", 512'(lines_written), 512'(0));
        checkOutput("mr_in_ready", 512'(in_ready), 512'(0));
        @(negedge clk);
        reset_n = 1'b1;
        pulse_rsp();
        @(negedge clk);
        checkOutput("mr_stray_lines", 512'(lines_written), 512'(0));
        checkOutput("mr_stray_busy", 512'(busy), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
